// File: rtl/lsu_ctrl.sv
// Load/store initiator between the execute stage and a word-addressed data
// memory. One request at a time: it checks alignment, drives the memory-side
// read/write encoding, and returns a formatted, register-ready load result.
// Sub-word stores can be done as read-modify-write. The memory's lane writes
// zero the bytes that are not selected, so a direct lane write would destroy
// the neighbouring bytes.
module lsu_ctrl #(
   parameter int ADDR_WIDTH  = 15,
   parameter bit RMW_SUBWORD = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_store,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_misalign,
   output logic [3:0]  wmem,
   output logic [4:0]  rmem,
   output logic [31:0] mem_addr,
   output logic [31:0] store_data,
   input  logic [31:0] load_data
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LD_ADDR = 3'd1,
      LD_DATA = 3'd2,
      ST_WR   = 3'd3,
      RMW_RD  = 3'd4,
      RMW_WR  = 3'd5
   } state_t;

   state_t                state_reg;
   logic [2:0]            funct3_reg;
   logic [ADDR_WIDTH+1:0] addr_reg;
   logic [31:0]           wdata_reg;

   logic                  req_bad;
   logic [1:0]            off;
   logic [3:0]            lane_mask;
   logic [31:0]           load_shifted;
   logic [31:0]           load_fmt;
   logic [31:0]           merge_data;
   logic [31:0]           mem_word;

   // Reset is included so nothing is accepted while rst is held.
   assign req_ready = (state_reg == IDLE) && !rst;

   assign off      = addr_reg[1:0];
   assign mem_word = {{(32-ADDR_WIDTH){1'b0}}, addr_reg[ADDR_WIDTH+1:2]};

   // Legality of the incoming request: funct3 encoding and natural alignment.
   always_comb begin
      req_bad = 1'b0;
      case (req_funct3)
         3'b000:  req_bad = 1'b0;
         3'b001:  req_bad = req_addr[0];
         3'b010:  req_bad = (req_addr[1:0] != 2'b00);
         3'b100:  req_bad = req_store;
         3'b101:  req_bad = req_store | req_addr[0];
         default: req_bad = 1'b1;
      endcase
   end

   // Byte-lane mask of the captured access; size lives in funct3[1:0].
   always_comb begin
      lane_mask = 4'b1111;
      case (funct3_reg[1:0])
         2'b00:   lane_mask = 4'b0001 << off;
         2'b01:   lane_mask = off[1] ? 4'b1100 : 4'b0011;
         default: lane_mask = 4'b1111;
      endcase
   end

   // Load result: shift the addressed lane down, then sign or zero extend.
   always_comb begin
      load_shifted = load_data >> {off, 3'b000};
      load_fmt     = load_data;
      case (funct3_reg[1:0])
         2'b00:   load_fmt = {{24{~funct3_reg[2] & load_shifted[7]}},  load_shifted[7:0]};
         2'b01:   load_fmt = {{16{~funct3_reg[2] & load_shifted[15]}}, load_shifted[15:0]};
         default: load_fmt = load_data;
      endcase
   end

   // Read-modify-write merge: old word with the stored lane(s) replaced.
   always_comb begin
      merge_data = load_data;
      if (funct3_reg[1:0] == 2'b00)
         merge_data[{off, 3'b000} +: 8] = wdata_reg[7:0];
      else if (funct3_reg[1:0] == 2'b01)
         merge_data[{off[1], 4'b0000} +: 16] = wdata_reg[15:0];
   end

   // Memory-side outputs decoded from state; writes only in ST_WR / RMW_WR so
   // an asynchronous reset cancels any write at once.
   always_comb begin
      wmem       = 4'b0000;
      rmem       = 5'b00000;
      mem_addr   = 32'h0;
      store_data = 32'h0;
      case (state_reg)
         LD_ADDR, LD_DATA: begin
            mem_addr = mem_word;
            rmem     = {(funct3_reg[2:1] == 2'b00), lane_mask};
         end
         ST_WR: begin
            mem_addr   = mem_word;
            wmem       = lane_mask;
            store_data = wdata_reg;
         end
         RMW_RD: begin
            mem_addr = mem_word;
            rmem     = 5'b01111;
         end
         RMW_WR: begin
            mem_addr   = mem_word;
            wmem       = 4'b1111;
            store_data = merge_data;
         end
         default: ;
      endcase
   end

   // Control FSM with registered response outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         funct3_reg    <= 3'b000;
         addr_reg      <= '0;
         wdata_reg     <= 32'h0;
         resp_valid    <= 1'b0;
         resp_rdata    <= 32'h0;
         resp_misalign <= 1'b0;
      end else begin
         resp_valid    <= 1'b0;
         resp_misalign <= 1'b0;
         resp_rdata    <= 32'h0;
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  funct3_reg <= req_funct3;
                  addr_reg   <= req_addr[ADDR_WIDTH+1:0];
                  wdata_reg  <= req_wdata;
                  if (req_bad) begin
                     resp_valid    <= 1'b1;
                     resp_misalign <= 1'b1;
                  end else if (!req_store) begin
                     state_reg <= LD_ADDR;
                  end else if (RMW_SUBWORD && (req_funct3[1:0] != 2'b10)) begin
                     state_reg <= RMW_RD;
                  end else begin
                     state_reg <= ST_WR;
                  end
               end
            end
            LD_ADDR: state_reg <= LD_DATA;
            LD_DATA: begin
               resp_rdata <= load_fmt;
               resp_valid <= 1'b1;
               state_reg  <= IDLE;
            end
            ST_WR: begin
               resp_valid <= 1'b1;
               state_reg  <= IDLE;
            end
            RMW_RD: state_reg <= RMW_WR;
            RMW_WR: begin
               resp_valid <= 1'b1;
               state_reg  <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed testbench for lsu_ctrl with a behavioural word memory whose lane
// writes zero unselected bytes and whose read data appears one cycle late.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_store = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_misalign;
   logic [3:0]  wmem;
   logic [4:0]  rmem;
   logic [31:0] mem_addr;
   logic [31:0] store_data;
   logic [31:0] load_data;

   int checks = 0;
   int passed = 0;

   logic [31:0] mem [0:63];
   logic        bd_we = 1'b0;
   logic [5:0]  bd_addr = 6'd0;
   logic [31:0] bd_data = 32'h0;

   lsu_ctrl #(.ADDR_WIDTH(15), .RMW_SUBWORD(1'b1)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misalign(resp_misalign),
      .wmem(wmem), .rmem(rmem), .mem_addr(mem_addr), .store_data(store_data),
      .load_data(load_data)
   );

   always #5 clk = ~clk;

   // Memory model: backdoor preload, lane writes zero other bytes, registered read.
   always @(posedge clk) begin
      if (bd_we)
         mem[bd_addr] <= bd_data;
      else if (wmem != 4'b0000 && mem_addr < 32'd64)
         mem[mem_addr[5:0]] <= {wmem[3] ? store_data[31:24] : 8'h00,
                                wmem[2] ? store_data[23:16] : 8'h00,
                                wmem[1] ? store_data[15:8]  : 8'h00,
                                wmem[0] ? store_data[7:0]   : 8'h00};
      load_data <= (mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'h0;
   end

   task automatic preload(input logic [5:0] a, input logic [31:0] d);
      @(negedge clk); bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(posedge clk); #1; bd_we = 1'b0;
   endtask

   // Presents one request and returns just after its accept edge.
   task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // Counts negedges since the accept edge until resp_valid, bounded.
   task automatic wait_resp(input int start, output int n);
      n = start;
      while (n < 8) begin
         @(negedge clk);
         n++;
         if (resp_valid) break;
      end
   endtask

   task automatic test_reset();
      @(negedge clk); @(negedge clk);
      checks++; if (resp_valid !== 1'b0) $display("FAIL rst_resp_valid got %b want 0", resp_valid); else passed++;
      checks++; if (resp_rdata !== 32'h0) $display("FAIL rst_resp_rdata got %h want 0", resp_rdata); else passed++;
      checks++; if (resp_misalign !== 1'b0) $display("FAIL rst_misalign got %b want 0", resp_misalign); else passed++;
      checks++; if (wmem !== 4'h0) $display("FAIL rst_wmem got %b want 0000", wmem); else passed++;
      checks++; if (rmem !== 5'h0) $display("FAIL rst_rmem got %b want 00000", rmem); else passed++;
      checks++; if (mem_addr !== 32'h0) $display("FAIL rst_mem_addr got %h want 0", mem_addr); else passed++;
      checks++; if (store_data !== 32'h0) $display("FAIL rst_store_data got %h want 0", store_data); else passed++;
      checks++; if (req_ready !== 1'b0) $display("FAIL rst_ready_held got %b want 0", req_ready); else passed++;
      rst = 1'b0; #1;
      checks++; if (req_ready !== 1'b1) $display("FAIL rst_ready_release got %b want 1", req_ready); else passed++;
      $display("reset: checked idle outputs");
   endtask

   task automatic test_load_word();
      int n;
      preload(6'd5, 32'h8899AABB);
      issue(1'b0, 3'b010, 32'h14, 32'h0);
      @(negedge clk);
      checks++; if (mem_addr !== 32'd5) $display("FAIL lw_addr_c1 got %h want 5", mem_addr); else passed++;
      checks++; if (rmem !== 5'b01111) $display("FAIL lw_rmem_c1 got %b want 01111", rmem); else passed++;
      @(negedge clk);
      checks++; if (mem_addr !== 32'd5) $display("FAIL lw_addr_c2 got %h want 5", mem_addr); else passed++;
      checks++; if (rmem !== 5'b01111) $display("FAIL lw_rmem_c2 got %b want 01111", rmem); else passed++;
      wait_resp(2, n);
      checks++; if (n !== 3) $display("FAIL lw_latency got %0d want 3", n); else passed++;
      checks++; if (resp_rdata !== 32'h8899AABB) $display("FAIL lw_rdata got %h want 8899aabb", resp_rdata); else passed++;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b0) $display("FAIL lw_pulse got %b want 0", resp_valid); else passed++;
      $display("LW 0x14: latency %0d", n);
   endtask

   task automatic test_load_subword();
      logic [2:0]  f3 [4] = '{3'b000, 3'b100, 3'b101, 3'b001};
      logic [31:0] ad [4] = '{32'h17, 32'h16, 32'h16, 32'h14};
      logic [4:0]  rm [4] = '{5'b11000, 5'b00100, 5'b01100, 5'b10011};
      logic [31:0] ex [4] = '{32'hFFFFFF88, 32'h00000099, 32'h00008899, 32'hFFFFAABB};
      for (int i = 0; i < 4; i++) begin
         int n;
         issue(1'b0, f3[i], ad[i], 32'h0);
         @(negedge clk);
         checks++; if (rmem !== rm[i]) $display("FAIL ld%0d_rmem got %b want %b", i, rmem, rm[i]); else passed++;
         wait_resp(1, n);
         checks++; if (n !== 3 || resp_rdata !== ex[i])
            $display("FAIL ld%0d_rdata got %h (cycle %0d) want %h (cycle 3)", i, resp_rdata, n, ex[i]);
         else passed++;
         $display("load funct3 %b addr %h: rdata %h", f3[i], ad[i], resp_rdata);
      end
   endtask

   task automatic test_rmw();
      int n;
      issue(1'b1, 3'b000, 32'h15, 32'h12345677);
      @(negedge clk);
      checks++; if (wmem !== 4'b0000 || rmem !== 5'b01111)
         $display("FAIL sb_rmw_rd got wmem %b rmem %b want 0000 01111", wmem, rmem); else passed++;
      @(negedge clk);
      checks++; if (wmem !== 4'b1111) $display("FAIL sb_rmw_wr_wmem got %b want 1111", wmem); else passed++;
      checks++; if (store_data !== 32'h889977BB) $display("FAIL sb_merge got %h want 889977bb", store_data); else passed++;
      wait_resp(2, n);
      checks++; if (n !== 3 || resp_misalign !== 1'b0)
         $display("FAIL sb_resp got cycle %0d misalign %b want cycle 3 misalign 0", n, resp_misalign); else passed++;
      issue(1'b0, 3'b010, 32'h14, 32'h0);
      wait_resp(0, n);
      checks++; if (resp_rdata !== 32'h889977BB) $display("FAIL sb_readback got %h want 889977bb", resp_rdata); else passed++;
      issue(1'b1, 3'b001, 32'h16, 32'h0000CAFE);
      wait_resp(0, n);
      checks++; if (n !== 3) $display("FAIL sh_latency got %0d want 3", n); else passed++;
      @(negedge clk);
      checks++; if (mem[5] !== 32'hCAFE77BB) $display("FAIL sh_mem got %h want cafe77bb", mem[5]); else passed++;
      $display("RMW SB/SH: word 5 = %h", mem[5]);
   endtask

   task automatic test_misalign();
      logic        st [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [2:0]  f3 [4] = '{3'b001, 3'b010, 3'b011, 3'b011};
      logic [31:0] ad [4] = '{32'h15, 32'h16, 32'h14, 32'h14};
      for (int i = 0; i < 4; i++) begin
         int n;
         int first;
         logic act;
         logic mis;
         logic [31:0] rd;
         act = 1'b0; first = 0; mis = 1'b0; rd = 32'hX;
         issue(st[i], f3[i], ad[i], 32'hFFFFFFFF);
         for (n = 1; n <= 4; n++) begin
            @(negedge clk);
            if (wmem !== 4'b0000 || rmem !== 5'b00000) act = 1'b1;
            if (resp_valid === 1'b1 && first == 0) begin
               first = n; mis = resp_misalign; rd = resp_rdata;
            end
         end
         checks++; if (first !== 1) $display("FAIL err%0d_latency got %0d want 1", i, first); else passed++;
         checks++; if (mis !== 1'b1 || rd !== 32'h0)
            $display("FAIL err%0d_resp got misalign %b rdata %h want 1 00000000", i, mis, rd); else passed++;
         checks++; if (act !== 1'b0) $display("FAIL err%0d_memact got %b want 0", i, act); else passed++;
         $display("illegal store=%b funct3 %b addr %h: misalign %b", st[i], f3[i], ad[i], mis);
      end
      checks++; if (mem[5] !== 32'hCAFE77BB) $display("FAIL err_mem got %h want cafe77bb", mem[5]); else passed++;
   endtask

   task automatic test_reset_mid();
      logic wrote;
      logic resp;
      wrote = 1'b0; resp = 1'b0;
      preload(6'd6, 32'h11223344);
      issue(1'b1, 3'b000, 32'h18, 32'h000000AB);
      @(negedge clk);
      checks++; if (rmem !== 5'b01111 || wmem !== 4'b0000)
         $display("FAIL rstmid_rmw_rd got rmem %b wmem %b want 01111 0000", rmem, wmem); else passed++;
      rst = 1'b1; #1;
      checks++; if (wmem !== 4'b0000 || rmem !== 5'b00000)
         $display("FAIL rstmid_async got wmem %b rmem %b want 0000 00000", wmem, rmem); else passed++;
      @(posedge clk); #1;
      if (wmem === 4'b1111) wrote = 1'b1;
      @(negedge clk);
      rst = 1'b0; #1;
      checks++; if (req_ready !== 1'b1) $display("FAIL rstmid_ready got %b want 1", req_ready); else passed++;
      repeat (4) begin
         @(negedge clk);
         if (wmem === 4'b1111) wrote = 1'b1;
         if (resp_valid !== 1'b0) resp = 1'b1;
      end
      checks++; if (wrote !== 1'b0) $display("FAIL rstmid_write got %b want 0", wrote); else passed++;
      checks++; if (resp !== 1'b0) $display("FAIL rstmid_resp got %b want 0", resp); else passed++;
      checks++; if (mem[6] !== 32'h11223344) $display("FAIL rstmid_mem got %h want 11223344", mem[6]); else passed++;
      $display("reset during RMW_RD: word 6 = %h", mem[6]);
   endtask

   task automatic test_back_to_back();
      int n;
      @(negedge clk);
      req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
      @(posedge clk); #1;
      req_store = 1'b0;
      @(negedge clk);
      checks++; if (wmem !== 4'b1111 || mem_addr !== 32'd8 || store_data !== 32'hDEADBEEF)
         $display("FAIL b2b_sw got wmem %b addr %h data %h want 1111 8 deadbeef", wmem, mem_addr, store_data); else passed++;
      checks++; if (req_ready !== 1'b0) $display("FAIL b2b_busy got %b want 0", req_ready); else passed++;
      @(negedge clk);
      checks++; if (resp_valid !== 1'b1 || req_ready !== 1'b1)
         $display("FAIL b2b_sw_resp got valid %b ready %b want 1 1", resp_valid, req_ready); else passed++;
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_resp(0, n);
      checks++; if (n !== 3) $display("FAIL b2b_lw_latency got %0d want 3", n); else passed++;
      checks++; if (resp_rdata !== 32'hDEADBEEF) $display("FAIL b2b_lw_rdata got %h want deadbeef", resp_rdata); else passed++;
      $display("SW/LW back-to-back 0x20: rdata %h", resp_rdata);
   endtask

   initial begin
      test_reset();
      test_load_word();
      test_load_subword();
      test_rmw();
      test_misalign();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
